// File: rtl/sr_ff_bank_if.sv
// Request/status bundle for sr_ff_bank.
//   en, s, r         : per-channel enable, set and reset requests (WIDTH each)
//   clr              : clear of the sticky conflict flags and the conflict counter
//   q                : flip-flop outputs (WIDTH)
//   conflict         : per-channel conflict pulse (WIDTH)
//   conflict_sticky  : per-channel latched conflict (WIDTH)
//   conflict_cnt     : saturating count of cycles that had a conflict (CNT_W)
interface sr_ff_bank_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) ();
   logic [WIDTH-1:0] en;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] r;
   logic             clr;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] conflict;
   logic [WIDTH-1:0] conflict_sticky;
   logic [CNT_W-1:0] conflict_cnt;

   modport master (
      output en, s, r, clr,
      input  q, conflict, conflict_sticky, conflict_cnt
   );

   modport slave (
      input  en, s, r, clr,
      output q, conflict, conflict_sticky, conflict_cnt
   );
endinterface

// File: rtl/sr_ff_bank.sv
// Multi-channel synchronous SR flip-flop bank with a selectable S=R=1
// resolution, an optional rising-edge request mode and conflict monitoring.
//   clk      : clock, all state changes on the rising edge
//   reset_n  : synchronous active-low reset
//   bus      : sr_ff_bank_if slave (en/s/r/clr in; q/conflict/sticky/cnt out)
module sr_ff_bank #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned CONFLICT_MODE = 0,
   parameter int unsigned EDGE_MODE     = 0,
   parameter int unsigned CNT_W         = 8
) (
   input logic          clk,
   input logic          reset_n,
   sr_ff_bank_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] conflict_r;
   logic [WIDTH-1:0] sticky_r;
   logic [WIDTH-1:0] s_d;
   logic [WIDTH-1:0] r_d;
   logic [CNT_W-1:0] cnt_r;

   logic [WIDTH-1:0] se_c;
   logic [WIDTH-1:0] re_c;
   logic [WIDTH-1:0] q_nxt_c;
   logic [WIDTH-1:0] conflict_nxt_c;
   logic [WIDTH-1:0] sticky_nxt_c;
   logic [CNT_W-1:0] cnt_nxt_c;
   logic             any_c;

   // Effective requests: raw levels, or rising edges against last cycle's inputs.
   always_comb begin
      se_c = bus.s;
      re_c = bus.r;
      if (EDGE_MODE != 0) begin
         se_c = bus.s & ~s_d;
         re_c = bus.r & ~r_d;
      end
   end

   // Per-channel next state; disabled channels hold.
   always_comb begin
      q_nxt_c = q_r;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (bus.en[i]) begin
            case ({se_c[i], re_c[i]})
               2'b01:   q_nxt_c[i] = 1'b0;
               2'b10:   q_nxt_c[i] = 1'b1;
               2'b11: begin
                  case (CONFLICT_MODE)
                     1:       q_nxt_c[i] = 1'b1;
                     2:       q_nxt_c[i] = 1'b0;
                     3:       q_nxt_c[i] = ~q_r[i];
                     default: q_nxt_c[i] = q_r[i];
                  endcase
               end
               default: q_nxt_c[i] = q_r[i];
            endcase
         end
      end
   end

   // Conflict monitoring; a conflict in the clr cycle survives the clear.
   always_comb begin
      conflict_nxt_c = bus.en & se_c & re_c;
      any_c          = |conflict_nxt_c;
      sticky_nxt_c   = bus.clr ? conflict_nxt_c : (sticky_r | conflict_nxt_c);
      cnt_nxt_c      = cnt_r;
      if (bus.clr) begin
         cnt_nxt_c = any_c ? CNT_W'(1) : '0;
      end else if (any_c && (cnt_r != CNT_MAX)) begin
         cnt_nxt_c = cnt_r + CNT_W'(1);
      end
   end

   // State registers; edge history updates regardless of en.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q_r        <= '0;
         conflict_r <= '0;
         sticky_r   <= '0;
         cnt_r      <= '0;
         s_d        <= '0;
         r_d        <= '0;
      end else begin
         q_r        <= q_nxt_c;
         conflict_r <= conflict_nxt_c;
         sticky_r   <= sticky_nxt_c;
         cnt_r      <= cnt_nxt_c;
         s_d        <= bus.s;
         r_d        <= bus.r;
      end
   end

   assign bus.q               = q_r;
   assign bus.conflict        = conflict_r;
   assign bus.conflict_sticky = sticky_r;
   assign bus.conflict_cnt    = cnt_r;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench: five bank instances (level mode with resolutions 0..3 and
// edge mode with set-dominant resolution) share one stimulus stream.
module tb_sr_ff_bank;

   localparam int NDUT = 5;
   localparam int MODE [NDUT] = '{0, 1, 2, 3, 1};
   localparam int EDGE [NDUT] = '{0, 0, 0, 0, 1};
   localparam int CMAX = 15;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] cf;
      logic [7:0] st;
      logic [3:0] cnt;
   } obs_t;
   typedef obs_t [NDUT-1:0] obs_all_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] en_v = '0, s_v = '0, r_v = '0;
   logic       clr_v = 1'b0;

   int checks = 0;
   int failures = 0;

   obs_all_t sb [$];
   obs_all_t act;

   // reference model state
   logic [7:0] mq [NDUT];
   logic [7:0] mcf [NDUT];
   logic [7:0] mst [NDUT];
   logic [7:0] msp [NDUT];
   logic [7:0] mrp [NDUT];
   int         mcnt [NDUT];

   always #5 clk = ~clk;

   sr_ff_bank_if #(.WIDTH(8), .CNT_W(4)) ifc0 ();
   sr_ff_bank_if #(.WIDTH(8), .CNT_W(4)) ifc1 ();
   sr_ff_bank_if #(.WIDTH(8), .CNT_W(4)) ifc2 ();
   sr_ff_bank_if #(.WIDTH(8), .CNT_W(4)) ifc3 ();
   sr_ff_bank_if #(.WIDTH(8), .CNT_W(4)) ifc4 ();

   assign ifc0.en = en_v; assign ifc0.s = s_v; assign ifc0.r = r_v; assign ifc0.clr = clr_v;
   assign ifc1.en = en_v; assign ifc1.s = s_v; assign ifc1.r = r_v; assign ifc1.clr = clr_v;
   assign ifc2.en = en_v; assign ifc2.s = s_v; assign ifc2.r = r_v; assign ifc2.clr = clr_v;
   assign ifc3.en = en_v; assign ifc3.s = s_v; assign ifc3.r = r_v; assign ifc3.clr = clr_v;
   assign ifc4.en = en_v; assign ifc4.s = s_v; assign ifc4.r = r_v; assign ifc4.clr = clr_v;

   sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(0), .EDGE_MODE(0), .CNT_W(4)) dut0 (.clk(clk), .reset_n(reset_n), .bus(ifc0));
   sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(1), .EDGE_MODE(0), .CNT_W(4)) dut1 (.clk(clk), .reset_n(reset_n), .bus(ifc1));
   sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(2), .EDGE_MODE(0), .CNT_W(4)) dut2 (.clk(clk), .reset_n(reset_n), .bus(ifc2));
   sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(3), .EDGE_MODE(0), .CNT_W(4)) dut3 (.clk(clk), .reset_n(reset_n), .bus(ifc3));
   sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(1), .EDGE_MODE(1), .CNT_W(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(ifc4));

   always_comb begin
      act[0] = {ifc0.q, ifc0.conflict, ifc0.conflict_sticky, ifc0.conflict_cnt};
      act[1] = {ifc1.q, ifc1.conflict, ifc1.conflict_sticky, ifc1.conflict_cnt};
      act[2] = {ifc2.q, ifc2.conflict, ifc2.conflict_sticky, ifc2.conflict_cnt};
      act[3] = {ifc3.q, ifc3.conflict, ifc3.conflict_sticky, ifc3.conflict_cnt};
      act[4] = {ifc4.q, ifc4.conflict, ifc4.conflict_sticky, ifc4.conflict_cnt};
   end

   // Behavioural model: apply the bank rules to one clock edge.
   task automatic model_step(input logic rn, input logic [7:0] e, input logic [7:0] sv,
                             input logic [7:0] rv, input logic c, output obs_all_t o);
      logic [7:0] cf;
      logic       se, re;
      for (int k = 0; k < NDUT; k++) begin
         if (!rn) begin
            mq[k] = '0; mcf[k] = '0; mst[k] = '0; mcnt[k] = 0;
            msp[k] = '0; mrp[k] = '0;
         end else begin
            cf = '0;
            for (int i = 0; i < 8; i++) begin
               se = sv[i] && !(EDGE[k] != 0 && msp[k][i]);
               re = rv[i] && !(EDGE[k] != 0 && mrp[k][i]);
               if (e[i]) begin
                  if (se && re) begin
                     cf[i] = 1'b1;
                     if (MODE[k] == 1) mq[k][i] = 1'b1;
                     else if (MODE[k] == 2) mq[k][i] = 1'b0;
                     else if (MODE[k] == 3) mq[k][i] = !mq[k][i];
                  end else if (se) begin
                     mq[k][i] = 1'b1;
                  end else if (re) begin
                     mq[k][i] = 1'b0;
                  end
               end
            end
            if (c) begin
               mst[k]  = cf;
               mcnt[k] = (cf != 0) ? 1 : 0;
            end else begin
               mst[k] = mst[k] | cf;
               if (cf != 0 && mcnt[k] < CMAX) mcnt[k] = mcnt[k] + 1;
            end
            mcf[k] = cf;
            msp[k] = sv;
            mrp[k] = rv;
         end
         o[k] = {mq[k], mcf[k], mst[k], 4'(mcnt[k])};
      end
   endtask

   // Drive one cycle of stimulus and queue the response the model predicts.
   task automatic cyc(input logic rn, input logic [7:0] e, input logic [7:0] sv,
                      input logic [7:0] rv, input logic c);
      obs_all_t exp_o;
      @(negedge clk);
      reset_n = rn; en_v = e; s_v = sv; r_v = rv; clr_v = c;
      model_step(rn, e, sv, rv, c, exp_o);
      sb.push_back(exp_o);
   endtask

   task automatic chk(input string name, input int k, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s dut%0d at %0t: got %02h want %02h", name, k, $time, got, want);
      end
   endtask

   // Monitor: every edge the bank presents a fresh response; compare it.
   initial begin
      obs_all_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < NDUT; k++) begin
               chk("q", k, act[k].q, e[k].q);
               chk("conflict", k, act[k].cf, e[k].cf);
               chk("sticky", k, act[k].st, e[k].st);
               chk("cnt", k, 8'(act[k].cnt), 8'(e[k].cnt));
            end
         end
      end
   end

   initial begin
      // reset with s high, then idle
      cyc(1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
      repeat (5) cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      // set/reset with enables
      cyc(1'b1, 8'h0F, 8'hFF, 8'h00, 1'b0);
      cyc(1'b1, 8'hFF, 8'h00, 8'h05, 1'b0);
      // clear q, then conflicts on channel 0
      cyc(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0);
      cyc(1'b1, 8'hFF, 8'h00, 8'h00, 1'b1);
      repeat (3) cyc(1'b1, 8'h01, 8'h01, 8'h01, 1'b0);
      // edge behaviour: r pulse, held s, r pulse, s still held
      cyc(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0);
      cyc(1'b1, 8'hFF, 8'h00, 8'h01, 1'b0);
      repeat (4) cyc(1'b1, 8'hFF, 8'h01, 8'h00, 1'b0);
      cyc(1'b1, 8'hFF, 8'h01, 8'h01, 1'b0);
      repeat (4) cyc(1'b1, 8'hFF, 8'h01, 8'h00, 1'b0);
      // lost edge while disabled
      cyc(1'b1, 8'h00, 8'h02, 8'h00, 1'b0);
      cyc(1'b1, 8'hFF, 8'h02, 8'h00, 1'b0);
      // counter saturation and clr interaction
      repeat (20) cyc(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      cyc(1'b1, 8'h01, 8'h01, 8'h01, 1'b1);
      cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
      // reset in the middle of sustained conflict
      repeat (7) cyc(1'b1, 8'h01, 8'h01, 8'h01, 1'b0);
      cyc(1'b0, 8'h01, 8'h01, 8'h01, 1'b0);
      repeat (3) cyc(1'b1, 8'h01, 8'h01, 8'h01, 1'b0);
      // random traffic
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 39) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 9) == 0));
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
Parametrised multi-channel synchronous SR flip-flop bank. It succeeds the single-bit SR flip-flop with per-channel enables and a defined, selectable resolution for S=R=1; no X is ever driven. An optional edge-triggered input mode is provided, along with conflict monitoring (per-channel flag, sticky flag, saturating cycle counter). Used as a status/event latch array in control paths.

Parameters:
WIDTH, 8, number of independent SR channels (1..32).
CONFLICT_MODE, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
EDGE_MODE, 0, 0 = level-sensitive s/r; 1 = act only on rising edge of s/r (per channel).
CNT_W, 8, width of conflict cycle counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  synchronous, active-low reset; one clock, sampled on rising edge of clk.
en  input  WIDTH  per-channel update enable.
s  input  WIDTH  per-channel set request.
r  input  WIDTH  per-channel reset request.
clr  input  1  synchronous clear of conflict_sticky and conflict_cnt (q unaffected).
q  output  WIDTH  flip-flop outputs, registered.
conflict  output  WIDTH  registered; 1 for one cycle after an effective S=R=1 on an enabled channel.
conflict_sticky  output  WIDTH  registered; latches conflict until clr or reset.
conflict_cnt  output  CNT_W  registered; number of cycles with at least one conflict, saturating.

Behaviour:
- Reset (reset_n=0 at rising edge): q=0, conflict=0, conflict_sticky=0, conflict_cnt=0, edge-history registers s_d=r_d=0. Reset overrides all other inputs, including mid-sequence.
- Effective requests: EDGE_MODE=0: se=s, re=r. EDGE_MODE=1: se=s&~s_d, re=r&~r_d, where s_d/r_d register s/r every cycle, independent of en.
  - The first cycle after reset with s already high counts as an edge.
- Per channel i, when en[i]=1, the next q[i] is:
  - se=0, re=0: hold.
  - se=0, re=1: 0.
  - se=1, re=0: 1.
  - se=1, re=1: resolved by CONFLICT_MODE (hold / 1 / 0 / ~q).
- en[i]=0: q[i] holds. Requests are ignored and no conflict is flagged; edge history still updates, so a rising edge arriving while disabled is lost.
- Latency: q, conflict, sticky and count all update on the same edge that samples the inputs (1-cycle latency, input to output).
- conflict[i] (next) = en[i] & se[i] & re[i]. It is a single-cycle pulse per conflicting cycle; in level mode a sustained conflict keeps it high.
- conflict_sticky (next) = clr ? conflict_next : (conflict_sticky | conflict_next). A new conflict in the same cycle as clr survives.
- conflict_cnt, where any = |conflict_next:
  - clr=1: next = any ? 1 : 0.
  - clr=0: increment by 1 when any=1 and cnt < 2^CNT_W-1; otherwise hold.
  - Multiple channels conflicting in one cycle count once.
- Invalid CONFLICT_MODE values (>3) behave as hold.
- Channels are fully independent; there is no cross-channel priority.

Test Plan:
- Reset/hold: WIDTH=8; drive reset_n=0 with s=0xFF for 1 cycle -> q=0x00, cnt=0. Release with s=r=0 for 5 cycles -> q stays 0x00.
- Set/reset/enable: en=0x0F, s=0xFF, r=0x00 -> q=0x0F. Then en=0xFF, s=0, r=0x05 -> q=0x0A.
- Conflict modes: q=0x00 then s=r=0x01 with en=0x01 for 3 cycles:
  - mode 0 -> q[0]=0,0,0.
  - mode 1 -> q[0]=1,1,1.
  - mode 2 -> q[0]=0,0,0.
  - mode 3 -> q[0]=1,0,1.
  - All modes: conflict[0]=1 each cycle, cnt=3.
- Edge mode (EDGE_MODE=1): hold s[0]=1 for 4 cycles after q cleared by r pulse -> q[0]=1. Then a single r[0] pulse -> q[0]=0. q[0] stays 0 while s[0] remains high, with no re-set.
- Counter/clr: CNT_W=4; 20 conflicting cycles -> cnt saturates at 15. Assert clr with a conflict in the same cycle -> cnt=1, sticky bit stays 1. clr with no conflict -> cnt=0, sticky=0.
- Reset mid-operation: during sustained conflict in mode 3 with cnt=7, pulse reset_n=0 for one cycle -> q, conflict, sticky, cnt all 0 on that edge. Counting restarts at 1 on the next conflicting cycle.
